// File: rtl/pid_scheduler.sv
// pid_scheduler: sequences the e-bike current loop.
// It generates the decimation strobe, latches the signed current error for the PID,
// and detects when the rider has stopped pedaling.
// It also soft-starts motor drive by clamping the PID magnitude under a rising limit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no drive, PID integrator held clear, error forced to zero
// RAMP  | drive clamped to a limit that grows by RAMP_STEP per tick
// RUN   | drive passed straight through from the PID
// (11)  | unreachable, falls back to IDLE
module pid_scheduler #(
    parameter bit          FAST_SIM    = 1'b1,
    parameter logic [3:0]  PED_TIMEOUT = 4'd6,
    parameter logic [11:0] RAMP_STEP   = 12'h100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence_rise,
    input  logic        brake_n,
    input  logic [11:0] target_curr,
    input  logic [11:0] avg_curr,
    input  logic        avg_vld,
    input  logic [11:0] drv_mag_in,
    output logic [12:0] error,
    output logic        not_pedaling,
    output logic        decim_tick,
    output logic [11:0] drv_mag_out,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RAMP = 2'b01,
        RUN  = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t      stateQ;
    state_t      stateNext;
    logic [19:0] decimCnt;
    logic [3:0]  pedTimer;
    logic [11:0] limit;
    logic [11:0] limitNext;
    logic [12:0] rampSum;
    logic        rampDone;
    logic        pedIdle;
    logic        exitCond;
    logic        nextIdle;
    logic [12:0] currDiff;
    logic [11:0] drvNext;

    assign state      = stateQ;
    assign pedIdle    = (pedTimer == PED_TIMEOUT);
    assign exitCond   = !brake_n || pedIdle;
    assign nextIdle   = (stateNext == IDLE);
    assign rampSum    = {1'b0, limit} + {1'b0, RAMP_STEP};
    assign rampDone   = rampSum[12] || (rampSum[11:0] == 12'hFFF);
    assign currDiff   = {1'b0, target_curr} - {1'b0, avg_curr};

    // Decimation strobe: all-ones decode of the free-running counter.
    assign decim_tick = FAST_SIM ? (&decimCnt[14:0]) : (&decimCnt);

    // Free-running decimation counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decimCnt <= '0;
        end else begin
            decimCnt <= decimCnt + 20'd1;
        end
    end

    // Pedal activity timer: cadence clears it, ticks age it up to the timeout.
    // It starts saturated so the bike never assumes pedaling at power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pedTimer <= PED_TIMEOUT;
        end else if (cadence_rise) begin
            pedTimer <= 4'd0;
        end else if (decim_tick && (pedTimer < PED_TIMEOUT)) begin
            pedTimer <= pedTimer + 4'd1;
        end
    end

    // Next-state and soft-start limit logic.
    always_comb begin
        stateNext = stateQ;
        limitNext = limit;
        case (stateQ)
            IDLE: begin
                // The cadence pulse also clears the pedal timer, so the saturated
                // timer seen in IDLE must not block this transition.
                if (cadence_rise && brake_n) begin
                    stateNext = RAMP;
                end
            end
            RAMP: begin
                if (exitCond) begin
                    stateNext = IDLE;
                end else if (decim_tick) begin
                    if (rampDone) begin
                        limitNext = 12'hFFF;
                        stateNext = RUN;
                    end else begin
                        limitNext = rampSum[11:0];
                    end
                end
            end
            RUN: begin
                if (exitCond) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (stateNext == IDLE) begin
            limitNext = 12'h000;
        end
    end

    // Drive selection uses the limit as it stands before this cycle's update.
    always_comb begin
        drvNext = 12'h000;
        if (!nextIdle) begin
            case (stateQ)
                RAMP:    drvNext = (drv_mag_in < limit) ? drv_mag_in : limit;
                RUN:     drvNext = drv_mag_in;
                default: drvNext = 12'h000;
            endcase
        end
    end

    // State, limit and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= IDLE;
            limit        <= 12'h000;
            not_pedaling <= 1'b1;
            error        <= 13'h0000;
            drv_mag_out  <= 12'h000;
        end else begin
            stateQ       <= stateNext;
            limit        <= limitNext;
            not_pedaling <= nextIdle;
            drv_mag_out  <= drvNext;
            if (nextIdle) begin
                error <= 13'h0000;
            end else if (avg_vld) begin
                error <= currDiff;
            end
        end
    end

endmodule

// File: doc/pid_scheduler.md
Name: pid_scheduler

Overview:
- Sequences the e-bike PID loop.
- Generates the decimation strobe, computes and latches the 13-bit signed current error, and derives `not_pedaling` from cadence activity and brake.
- Soft-starts motor drive through a rising magnitude limit applied to the PID's `drv_mag` output.
- Sits between the current-sense/cadence front end and the PID, and between the PID and the PWM/commutation logic.

Parameters:
- `FAST_SIM`, 1: decimation strobe decodes counter bits [14:0] when 1; all 20 bits when 0.
- `PED_TIMEOUT`, 4'd6: decimation ticks without a cadence rise before pedaling is declared stopped.
- `RAMP_STEP`, 12'h100: soft-start limit increment per decimation tick.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `cadence_rise` in 1: one-clk pulse per filtered cadence rising edge.
- `brake_n` in 1: brake lever, active low. Synchronised upstream.
- `target_curr` in 12: unsigned target current from the torque/assist mapping.
- `avg_curr` in 12: unsigned averaged motor current.
- `avg_vld` in 1: one-clk pulse when `avg_curr` is new.
- `drv_mag_in` in 12: unsigned PID drive magnitude.
- `error` out 13: signed error to the PID.
- `not_pedaling` out 1: PID integrator clear.
- `decim_tick` out 1: one-clk decimation strobe.
- `drv_mag_out` out 12: limited drive magnitude to PWM.
- `state` out 2: FSM state, for debug and verification.

Behaviour:
- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`. All registers clear on reset.
- Reset values: `error`=0, `not_pedaling`=1, `drv_mag_out`=0, `state`=IDLE(2'b00), `decim_tick`=0.
- Decimator:
  - 20-bit free-running counter, cleared at reset, increments every clk and wraps.
  - `decim_tick` is a combinational decode: &cnt[14:0] when FAST_SIM, else &cnt[19:0].
  - With FAST_SIM, the first tick falls in the 32768th clk after reset release (cnt=0x7FFF), then every 32768 clks.
- Pedal timer:
  - 4-bit counter. `cadence_rise` clears it to 0.
  - Otherwise each `decim_tick` increments it, saturating at PED_TIMEOUT.
  - `cadence_rise` wins over a coincident `decim_tick`.
  - `ped_idle` = (timer == PED_TIMEOUT).
  - The timer resets to PED_TIMEOUT, so pedaling is not assumed at power-up.
- FSM states: IDLE=00, RAMP=01, RUN=10; 11 is unreachable and recovers to IDLE.
  - Any state -> IDLE when ~`brake_n` | `ped_idle`. This has the highest priority.
  - IDLE -> RAMP on `cadence_rise` & `brake_n`. The same cycle also clears the pedal timer, so `ped_idle` deasserts the next clk.
  - RAMP:
    - `limit` (12-bit register) is 0 on entry.
    - On `decim_tick`, sum = {0,limit}+RAMP_STEP (13-bit).
    - If sum[12] | sum[11:0]==12'hFFF, then `limit`<=FFF and state<=RUN.
    - Else `limit`<=sum[11:0].
  - RUN: hold until an exit condition occurs.
  - `limit` clears to 0 whenever the next state is IDLE.
- `not_pedaling`: registered, equal to (state==IDLE). It updates on the same edge as `state`.
- Error:
  - On `avg_vld`, `error` <= {1'b0,target_curr} - {1'b0,avg_curr}, as a 13-bit two's complement value. The range is -4095..+4095, so no saturation is needed.
  - While the next state is IDLE, `error` is forced to 0; this overrides `avg_vld`.
  - Otherwise `error` holds between `avg_vld` pulses.
- Drive output: registered, 1-clk latency from `drv_mag_in`.
  - IDLE: 0.
  - RAMP: min(`drv_mag_in`, `limit`), using the `limit` value before the current-cycle update.
  - RUN: `drv_mag_in`.
  - Brake assertion yields `drv_mag_out`=0 on the first clk edge after ~`brake_n` is sampled.
- Reset mid-RAMP/RUN: all outputs go to reset values immediately (asynchronously). Resuming requires a new `cadence_rise`.

Test Plan:
- Reset release, FAST_SIM=1, no stimulus:
  - `decim_tick` first high at clk 32768 and then every 32768.
  - `not_pedaling`=1, `state`=00, `drv_mag_out`=0 throughout.
- `brake_n`=1, one `cadence_rise`, then a `cadence_rise` every 2 ticks, with `drv_mag_in`=0xFFF:
  - `state`=01 one clk after the pulse.
  - `drv_mag_out` steps 0x000, 0x100, ..., 0xF00, then 0xFFF after the 16th tick, with `state`=10.
- Continue stimulus and stop cadence at tick T:
  - `state`=00 and `not_pedaling`=1 on the clk after tick T+6.
  - `error`=0 and `drv_mag_out`=0 at that point.
- In RUN, `target_curr`=0x200, `avg_curr`=0x300, pulse `avg_vld`:
  - `error`=13'h1F00 (-256) next clk.
  - With `target_curr`=0xFFF and `avg_curr`=0, `error`=0x0FFF.
- In RAMP with `limit`=0x300 and `drv_mag_in`=0x120:
  - `drv_mag_out`=0x120.
  - With `drv_mag_in`=0x500, `drv_mag_out`=0x300.
  - Drop `brake_n`: next clk `state`=00, `drv_mag_out`=0, `not_pedaling`=1.
- `cadence_rise` coincident with the `decim_tick` that would reach PED_TIMEOUT:
  - The timer clears to 0 and `state` stays RAMP/RUN.
  - Pulse `rst_n` low mid-RAMP: outputs return to reset values without waiting for a clk.
